// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake bundle between the IF stage, the fetch queue and ID.
//   enq_*     : IF -> queue (valid/instr/pc in, ready out)
//   deq_*     : queue -> ID (valid/instr/pc/pc4 out, ready in)
//   flush     : redirect, drops every queued entry
//   count     : current occupancy
//   flush_cnt : saturating total of entries dropped by flush
// The slave modport is the queue's view; master is the driver/consumer view.
interface fetch_queue_if #(
  parameter int IW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enq_valid;
  logic [IW-1:0] enq_instr;
  logic [AW-1:0] enq_pc;
  logic          enq_ready;
  logic          deq_valid;
  logic [IW-1:0] deq_instr;
  logic [AW-1:0] deq_pc;
  logic [AW-1:0] deq_pc4;
  logic          deq_ready;
  logic          flush;
  logic [CW-1:0] count;
  logic [15:0]   flush_cnt;

  modport master (
    output enq_valid, enq_instr, enq_pc, deq_ready, flush,
    input  enq_ready, deq_valid, deq_instr, deq_pc, deq_pc4, count, flush_cnt
  );

  modport slave (
    input  enq_valid, enq_instr, enq_pc, deq_ready, flush,
    output enq_ready, deq_valid, deq_instr, deq_pc, deq_pc4, count, flush_cnt
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- circular-buffer instruction queue between IF and ID.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset (clears pointers, count, flush_cnt)
//   fq  : fetch_queue_if.slave (enq/deq handshakes, flush, count, flush_cnt)
// Head entry is presented combinationally (first-word fall-through). No
// enqueue bypass when full and no dequeue bypass when empty.
module fetch_queue #(
  parameter int IW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;
  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [IW-1:0] instr_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_d [DEPTH];

  logic          enq_fire;
  logic          deq_fire;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic [16:0]   flush_sum;

  // Pointer MSB only matters for wrap; the storage index is the low bits.
  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];

  assign fq.enq_ready = (count_q < DEPTH_C) && !fq.flush;
  assign fq.deq_valid = (count_q != '0) && !fq.flush;
  assign fq.deq_instr = instr_mem_q[rd_idx];
  assign fq.deq_pc    = pc_mem_q[rd_idx];
  assign fq.deq_pc4   = pc_mem_q[rd_idx] + AW'(4);
  assign fq.count     = count_q;
  assign fq.flush_cnt = flush_cnt_q;

  // ready/valid already fold in ~flush, so a flush cycle never fires either side.
  assign enq_fire = fq.enq_valid && fq.enq_ready;
  assign deq_fire = fq.deq_valid && fq.deq_ready;

  // One spare bit catches the carry so saturation is a simple test.
  assign flush_sum = {1'b0, flush_cnt_q} + 17'(count_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    if (fq.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + CW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + CW'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
      else if (deq_fire && !enq_fire) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (enq_fire) begin
      instr_mem_d[wr_idx] = fq.enq_instr;
      pc_mem_d[wr_idx]    = fq.enq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Storage is deliberately not reset; reads are qualified by deq_valid.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  typedef struct {
    int cnt;
    bit er;
    bit dv;
    int fc;
  } stat_t;

  logic clk = 1'b0;
  logic rst;

  fetch_queue_if #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .fq (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue of stored entries plus a flush counter.
  entry_t mdl[$];
  int     fc_m  = 0;
  bit     known = 0;

  // Scoreboards filled by the driver, drained by the monitor.
  entry_t exp_q[$];
  stat_t  stat_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit ev, input logic [31:0] pc, input logic [31:0] ins,
                      input bit dr, input bit fl, input bit r);
    stat_t  s;
    entry_t e;
    bit     do_deq;
    bit     do_enq;
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_instr = ins;
    bus.deq_ready = dr;
    bus.flush     = fl;
    rst           = r;
    if (known) begin
      s.cnt = mdl.size();
      s.er  = (mdl.size() < DEPTH) && !fl;
      s.dv  = (mdl.size() != 0) && !fl;
      s.fc  = fc_m;
      stat_q.push_back(s);
      if (mdl.size() != 0 && !fl && dr) exp_q.push_back(mdl[0]);
    end
    @(posedge clk);
    if (r) begin
      mdl.delete();
      fc_m  = 0;
      known = 1;
    end else if (known) begin
      if (fl) begin
        fc_m = (fc_m + mdl.size() > 65535) ? 65535 : fc_m + mdl.size();
        mdl.delete();
      end else begin
        do_deq = (mdl.size() != 0) && dr;
        do_enq = (mdl.size() < DEPTH) && ev;
        if (do_deq) void'(mdl.pop_front());
        if (do_enq) begin
          e.pc    = pc;
          e.instr = ins;
          e.pc4   = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
          mdl.push_back(e);
        end
      end
    end
    #1;
  endtask

  // Monitor: status every cycle, head payload whenever ID consumes.
  always @(negedge clk) begin
    stat_t  s;
    entry_t e;
    if (!done) begin
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        check("count",     bus.count,     s.cnt);
        check("enq_ready", bus.enq_ready, s.er);
        check("deq_valid", bus.deq_valid, s.dv);
        check("flush_cnt", bus.flush_cnt, s.fc);
      end
      if (bus.deq_valid && bus.deq_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_deq", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc",    bus.deq_pc,    e.pc);
          check("deq_instr", bus.deq_instr, e.instr);
          check("deq_pc4",   bus.deq_pc4,   e.pc4);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    // Reset; consumer held off while state is still unknown.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Fill to full, then a fifth enqueue that must be ignored.
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), $urandom, 0, 0, 0);
    step(1, 32'h100, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Drain across pointer wrap, refilling once slots free.
    step(0, 0,      0,        1, 0, 0);
    step(1, 32'h10, $urandom, 1, 0, 0);
    step(1, 32'h14, $urandom, 1, 0, 0);
    step(0, 0,      0,        1, 0, 0);
    step(0, 0,      0,        1, 0, 0);
    step(0, 0,      0,        1, 0, 0);
    step(0, 0,      0,        1, 0, 0);

    // Steady-state enqueue+dequeue at count=2.
    step(1, 32'h200, $urandom, 0, 0, 0);
    step(1, 32'h204, $urandom, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h208 + 32'(i * 4), $urandom, 1, 0, 0);

    // Flush at count=3 with simultaneous enq and deq.
    step(1, 32'h300, $urandom, 0, 0, 0);
    step(1, 32'h304, $urandom, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Build flush_cnt=5 with count=2, then reset mid-operation.
    step(1, 32'h400, $urandom, 0, 0, 0);
    step(1, 32'h404, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'h408, $urandom, 0, 0, 0);
    step(1, 32'h40C, $urandom, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 32'h410, $urandom, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    // PC + 4 wraps to zero.
    step(1, 32'hFFFF_FFFC, $urandom, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                       : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) < 7, pc, $urandom,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
    end

    // Drain what is left.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    done = 1;
    check("scoreboard_empty", exp_q.size() + stat_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
